// File: rtl/bus_pkg.sv
// Shared definitions for the parallel-bus driver endpoint.
// Packet destination ID lives in the top ID_W bits of every packet.
package bus_pkg;
   localparam int unsigned ID_W       = 8;
   localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
   localparam int unsigned DROP_CNT_W = 16;
   localparam int unsigned MAX_PKT_W  = 1024;

   // pkt is the packet zero-extended to MAX_PKT_W; w is its real width
   function automatic logic [ID_W-1:0] dest_id(input logic [MAX_PKT_W-1:0] pkt,
                                                input int unsigned w);
      return ID_W'(pkt >> (w - ID_W));
   endfunction
endpackage

// File: rtl/bus_sync_fifo.sv
// Synchronous show-ahead FIFO: write visible on dout one cycle after the write edge.
// Write on full is dropped unless a read happens the same cycle; read on empty is ignored.
module bus_sync_fifo #(
   parameter int unsigned bits  = 256,
   parameter int unsigned depth = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr,
   input  logic [bits-1:0] din,
   input  logic            rd,
   output logic [bits-1:0] dout,
   output logic            full,
   output logic            empty
);
   localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;
   localparam int unsigned CW = AW + 1;

   logic [bits-1:0] mem [depth];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            wr_en;
   logic            rd_en;

   // a read frees the slot on a full FIFO, so the write may proceed in the same cycle
   assign wr_en = wr && (!full || rd);
   assign rd_en = rd && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(wr_en) - CW'(rd_en);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem[wr_ptr] <= din;
   end

   assign full  = (count == CW'(depth));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];
endmodule

// File: rtl/bus_drvr_endpoint.sv
// Driver-side endpoint of the 9-driver bus: TX FIFO drained by pndng/pop, RX FIFO fed by push.
// One-cycle write-to-visible latency; full TX sets sticky tx_ovf, rejected deliveries bump drop_cnt.
module bus_drvr_endpoint
   import bus_pkg::*;
#(
   parameter int unsigned    bits      = 256,
   parameter int unsigned    depth     = 16,
   parameter logic [ID_W-1:0] id       = 8'd0,
   parameter logic [ID_W-1:0] broadcast = BCAST_ID
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  pndng,
   input  logic                  pop,
   output logic [bits-1:0]       D_pop,
   input  logic                  push,
   input  logic [bits-1:0]       D_push,
   input  logic                  tx_wr,
   input  logic [bits-1:0]       tx_data,
   output logic                  tx_full,
   output logic                  tx_ovf,
   input  logic                  rx_rd,
   output logic [bits-1:0]       rx_data,
   output logic                  rx_empty,
   output logic [DROP_CNT_W-1:0] drop_cnt
);
   logic            tx_empty;
   logic            rx_full;
   logic [ID_W-1:0] push_id;
   logic            id_match;
   logic            rx_accept;

   assign push_id   = dest_id(MAX_PKT_W'(D_push), bits);
   assign id_match  = (push_id == id) || (push_id == broadcast);
   assign rx_accept = push && id_match && (!rx_full || rx_rd);
   assign pndng     = !tx_empty;

   bus_sync_fifo #(.bits(bits), .depth(depth)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (tx_wr),
      .din   (tx_data),
      .rd    (pop),
      .dout  (D_pop),
      .full  (tx_full),
      .empty (tx_empty)
   );

   bus_sync_fifo #(.bits(bits), .depth(depth)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (push && id_match),
      .din   (D_push),
      .rd    (rx_rd),
      .dout  (rx_data),
      .full  (rx_full),
      .empty (rx_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_ovf   <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (tx_wr && tx_full && !pop) tx_ovf <= 1'b1;
         if (push && !rx_accept && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_bus_drvr_endpoint.sv
// Randomized directed bench for bus_drvr_endpoint against a queue-based reference model.
module tb_bus_drvr_endpoint;
   localparam int W = 256;
   localparam int D = 16;
   localparam logic [7:0] MY_ID = 8'd3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          pndng;
   logic          pop = 1'b0;
   logic [W-1:0]  D_pop;
   logic          push = 1'b0;
   logic [W-1:0]  D_push = '0;
   logic          tx_wr = 1'b0;
   logic [W-1:0]  tx_data = '0;
   logic          tx_full;
   logic          tx_ovf;
   logic          rx_rd = 1'b0;
   logic [W-1:0]  rx_data;
   logic          rx_empty;
   logic [15:0]   drop_cnt;

   int n_vec = 0;
   int n_err = 0;
   bit full_chk = 1'b1;

   logic [W-1:0] tx_q[$];
   logic [W-1:0] rx_q[$];
   logic         m_ovf = 1'b0;
   int           m_drop = 0;

   bus_drvr_endpoint #(.bits(W), .depth(D), .id(MY_ID), .broadcast(8'hFF)) dut (
      .clk      (clk),
      .reset    (reset),
      .pndng    (pndng),
      .pop      (pop),
      .D_pop    (D_pop),
      .push     (push),
      .D_push   (D_push),
      .tx_wr    (tx_wr),
      .tx_data  (tx_data),
      .tx_full  (tx_full),
      .tx_ovf   (tx_ovf),
      .rx_rd    (rx_rd),
      .rx_data  (rx_data),
      .rx_empty (rx_empty),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] mk_pkt(input logic [7:0] dst);
      logic [W-1:0] p;
      for (int i = 0; i < W / 32; i++) p[i*32 +: 32] = $urandom;
      p[W-1 -: 8] = dst;
      return p;
   endfunction

   function automatic logic [7:0] rand_dst();
      case ($urandom_range(0, 2))
         0:       return MY_ID;
         1:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic check_all();
      chk("pndng", W'(pndng), W'(tx_q.size() != 0));
      chk("tx_full", W'(tx_full), W'(tx_q.size() == D));
      chk("tx_ovf", W'(tx_ovf), W'(m_ovf));
      chk("rx_empty", W'(rx_empty), W'(rx_q.size() == 0));
      chk("drop_cnt", W'(drop_cnt), W'(m_drop));
      if (tx_q.size() != 0) chk("D_pop", D_pop, tx_q[0]);
      if (rx_q.size() != 0) chk("rx_data", rx_data, rx_q[0]);
   endtask

   // Apply the current strobes for one clock: advance the model, clock the DUT, compare.
   task automatic tick();
      if (reset) begin
         tx_q.delete();
         rx_q.delete();
         m_ovf  = 1'b0;
         m_drop = 0;
      end else begin
         int tn = tx_q.size();
         int rn = rx_q.size();
         bit hit = (D_push[W-1 -: 8] == MY_ID) || (D_push[W-1 -: 8] == 8'hFF);
         bit acc = push && hit && (rn < D || rx_rd);
         if (pop && tn > 0) void'(tx_q.pop_front());
         if (tx_wr) begin
            if (tn < D || pop) tx_q.push_back(tx_data);
            else m_ovf = 1'b1;
         end
         if (rx_rd && rn > 0) void'(rx_q.pop_front());
         if (acc) rx_q.push_back(D_push);
         else if (push && m_drop < 65535) m_drop++;
      end
      @(posedge clk);
      #1;
      reset = 1'b0; tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
      if (full_chk) check_all();
   endtask

   initial begin
      // reset state
      reset = 1'b1; tick();
      reset = 1'b1; tick();
      chk("rst_pndng", W'(pndng), W'(0));
      chk("rst_tx_full", W'(tx_full), W'(0));
      chk("rst_tx_ovf", W'(tx_ovf), W'(0));
      chk("rst_rx_empty", W'(rx_empty), W'(1));
      chk("rst_drop", W'(drop_cnt), W'(0));

      // fill and drain
      for (int i = 0; i < D; i++) begin tx_wr = 1'b1; tx_data = W'(i); tick(); end
      chk("fill_full", W'(tx_full), W'(1));
      chk("fill_ovf_clear", W'(tx_ovf), W'(0));
      tx_wr = 1'b1; tx_data = W'(99); tick();
      chk("ovf_set", W'(tx_ovf), W'(1));
      for (int i = 0; i < D; i++) begin
         chk("pop_order", D_pop, W'(i));
         pop = 1'b1; tick();
      end
      chk("drain_pndng", W'(pndng), W'(0));
      pop = 1'b1; tick();

      // address filter
      reset = 1'b1; tick();
      push = 1'b1; D_push = mk_pkt(MY_ID); tick();
      push = 1'b1; D_push = mk_pkt(8'hFF); tick();
      push = 1'b1; D_push = mk_pkt(8'd5); tick();
      chk("filt_drop", W'(drop_cnt), W'(1));
      chk("filt_first", W'(rx_data[W-1 -: 8]), W'(MY_ID));
      rx_rd = 1'b1; tick();
      chk("filt_second", W'(rx_data[W-1 -: 8]), W'(8'hFF));
      rx_rd = 1'b1; tick();
      chk("filt_empty", W'(rx_empty), W'(1));
      rx_rd = 1'b1; tick();

      // RX overflow
      for (int i = 0; i < D; i++) begin push = 1'b1; D_push = mk_pkt(MY_ID); tick(); end
      push = 1'b1; D_push = mk_pkt(MY_ID); tick();
      chk("rxovf_drop", W'(drop_cnt), W'(2));
      push = 1'b1; rx_rd = 1'b1; D_push = mk_pkt(8'hFF); tick();
      chk("rxovf_accept_drop", W'(drop_cnt), W'(2));
      chk("rxovf_not_empty", W'(rx_empty), W'(0));
      for (int i = 0; i < D; i++) begin rx_rd = 1'b1; tick(); end
      chk("rxovf_drained", W'(rx_empty), W'(1));

      // boundary strobes
      tx_wr = 1'b1; pop = 1'b1; tx_data = mk_pkt(8'd0); tick();
      chk("empty_wrpop_pndng", W'(pndng), W'(1));
      for (int i = 0; i < D - 1; i++) begin tx_wr = 1'b1; tx_data = mk_pkt(8'd1); tick(); end
      tx_wr = 1'b1; pop = 1'b1; tx_data = mk_pkt(8'd2); tick();
      chk("full_wrpop_full", W'(tx_full), W'(1));
      chk("full_wrpop_ovf", W'(tx_ovf), W'(0));
      for (int i = 0; i < D; i++) begin pop = 1'b1; tick(); end

      // mid-operation reset
      for (int i = 0; i < 7; i++) begin
         push = 1'b1; D_push = mk_pkt(MY_ID);
         tx_wr = (i < 5); tx_data = mk_pkt(8'd7);
         tick();
      end
      reset = 1'b1; push = 1'b1; D_push = mk_pkt(MY_ID); tx_wr = 1'b1; tx_data = mk_pkt(8'd9);
      push = 1'b1; tick();
      chk("mrst_pndng", W'(pndng), W'(0));
      chk("mrst_rx_empty", W'(rx_empty), W'(1));
      chk("mrst_drop", W'(drop_cnt), W'(0));
      tick();
      chk("mrst_nostore", W'(pndng | !rx_empty), W'(0));

      // pointer wrap: 40 interleaved write/pop pairs on both FIFOs
      for (int i = 0; i < 40; i++) begin
         tx_wr = 1'b1; tx_data = mk_pkt(8'($urandom));
         push = 1'b1; D_push = mk_pkt(MY_ID);
         tick();
         pop = 1'b1; rx_rd = 1'b1; tick();
      end

      // random traffic
      for (int i = 0; i < 600; i++) begin
         tx_wr = ($urandom_range(0, 3) != 0); tx_data = mk_pkt(8'($urandom));
         pop   = ($urandom_range(0, 2) == 0);
         push  = ($urandom_range(0, 3) != 0); D_push = mk_pkt(rand_dst());
         rx_rd = ($urandom_range(0, 2) == 0);
         tick();
      end

      // drop counter saturation
      full_chk = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         push = 1'b1; D_push = mk_pkt((i % 2) ? 8'd5 : 8'd200);
         tick();
      end
      full_chk = 1'b1;
      tick();
      chk("drop_sat", W'(drop_cnt), W'(16'hFFFF));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
